// File: rtl/reg4_sequencer_pkg.sv
// reg4_sequencer shared types: op and MODO encodings, FSM states.
// Imported by the interface, the sequencer and the register model.
package reg4_pkg;

  localparam int MAX_SHIFT_DEF = 8;

  localparam logic [1:0] OP_SHIFT  = 2'b00;
  localparam logic [1:0] OP_ROTATE = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;
  localparam logic [1:0] MODO_HOLD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_ROTATE,
    ST_SETTLE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/reg4_sequencer_if.sv
// Command and response channels of reg4_sequencer.
// master: command producer / response consumer; slave: the sequencer.
interface reg4_sequencer_if
  import reg4_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
);
  logic                 CMD_VALID;
  logic                 CMD_READY;
  logic [1:0]           CMD_OP;
  logic                 CMD_DIR;
  logic [3:0]           CMD_COUNT;
  logic [3:0]           CMD_DATA;
  logic [MAX_SHIFT-1:0] CMD_SDATA;
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [MAX_SHIFT-1:0] RSP_DATA;
  logic [3:0]           RSP_Q;

  modport master (
    output CMD_VALID, CMD_OP, CMD_DIR,
    output CMD_COUNT, CMD_DATA, CMD_SDATA,
    input  CMD_READY,
    input  RSP_VALID, RSP_DATA, RSP_Q,
    output RSP_READY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DIR,
    input  CMD_COUNT, CMD_DATA, CMD_SDATA,
    output CMD_READY,
    output RSP_VALID, RSP_DATA, RSP_Q,
    input  RSP_READY
  );
endinterface

// File: rtl/register4.sv
// 4-bit shift/rotate/load register driven by reg4_sequencer.
// Ports: CLK, ENB, MODO, DIR, D, S_IN in; S_OUT (outgoing bit), Q out.
module register4
  import reg4_pkg::*;
(
  input  logic       CLK,
  input  logic       ENB,
  input  logic [1:0] MODO,
  input  logic       DIR,
  input  logic [3:0] D,
  input  logic       S_IN,
  output logic       S_OUT,
  output logic [3:0] Q
);
  // Bit leaving the register on the next shift.
  assign S_OUT = DIR ? Q[0] : Q[3];

  always_ff @(posedge CLK) begin
    if (ENB) begin
      unique case (MODO)
        MODO_SHIFT:
          Q <= DIR ? {S_IN, Q[3:1]}
                   : {Q[2:0], S_IN};
        MODO_ROT:
          Q <= DIR ? {Q[0], Q[3:1]}
                   : {Q[2:0], Q[3]};
        MODO_LOAD: Q <= D;
        default:   Q <= Q;
      endcase
    end
  end
endmodule

// File: rtl/reg4_sequencer.sv
// Command sequencer for register4: runs LOAD/SHIFT/ROTATE/NOP commands.
// Ports: CLK, RESET, bus (cmd/rsp), register drive ENB..S_IN, S_OUT, Q.
module reg4_sequencer
  import reg4_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
)
(
  input  logic       CLK,
  input  logic       RESET,
  reg4_sequencer_if.slave bus,
  output logic       ENB,
  output logic [1:0] MODO,
  output logic       DIR,
  output logic [3:0] D,
  output logic       S_IN,
  input  logic       S_OUT,
  input  logic [3:0] Q
);
  localparam int IW =
    (MAX_SHIFT > 1) ? $clog2(MAX_SHIFT) : 1;
  localparam logic [3:0] NMAX = 4'(MAX_SHIFT);

  state_t               r_state;
  logic                 r_ready;
  logic                 r_valid;
  logic [MAX_SHIFT-1:0] r_rdata;
  logic [MAX_SHIFT-1:0] r_sdata;
  logic [3:0]           r_rq;
  logic [3:0]           r_cnt;
  logic [3:0]           r_idx;
  logic                 r_enb;
  logic [1:0]           r_modo;
  logic                 r_dir;
  logic [3:0]           r_d;
  logic                 r_sin;

  logic       w_is_load;
  logic       w_is_shift;
  logic       w_is_rot;
  logic [3:0] w_scnt;
  logic [3:0] w_nidx;
  logic       w_last;

  assign w_scnt = (bus.CMD_COUNT > NMAX)
                ? NMAX : bus.CMD_COUNT;
  assign w_is_load  = bus.CMD_OP == OP_LOAD;
  assign w_is_shift = (bus.CMD_OP == OP_SHIFT)
                   && (bus.CMD_COUNT != 4'd0);
  assign w_is_rot   = (bus.CMD_OP == OP_ROTATE)
                   && (bus.CMD_COUNT != 4'd0);
  assign w_nidx = r_idx + 4'd1;
  assign w_last = w_nidx == r_cnt;

  assign ENB  = r_enb;
  assign MODO = r_modo;
  assign DIR  = r_dir;
  assign D    = r_d;
  assign S_IN = r_sin;

  assign bus.CMD_READY = r_ready;
  assign bus.RSP_VALID = r_valid;
  assign bus.RSP_DATA  = r_rdata;
  assign bus.RSP_Q     = r_rq;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_sdata <= '0;
      r_rq    <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_enb   <= 1'b0;
      r_modo  <= MODO_HOLD;
      r_dir   <= 1'b0;
      r_d     <= '0;
      r_sin   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.CMD_VALID) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_idx   <= '0;
            r_sdata <= bus.CMD_SDATA;
            unique case (1'b1)
              w_is_load: begin
                r_state <= ST_LOAD;
                r_cnt   <= 4'd1;
                r_enb   <= 1'b1;
                r_modo  <= MODO_LOAD;
                r_d     <= bus.CMD_DATA;
              end
              w_is_shift: begin
                r_state <= ST_SHIFT;
                r_cnt   <= w_scnt;
                r_enb   <= 1'b1;
                r_modo  <= MODO_SHIFT;
                r_dir   <= bus.CMD_DIR;
                r_sin   <= bus.CMD_SDATA[0];
              end
              w_is_rot: begin
                r_state <= ST_ROTATE;
                r_cnt   <= bus.CMD_COUNT;
                r_enb   <= 1'b1;
                r_modo  <= MODO_ROT;
                r_dir   <= bus.CMD_DIR;
              end
              default: begin
                r_state <= ST_SETTLE;
                r_cnt   <= '0;
              end
            endcase
          end
        end
        ST_LOAD: begin
          r_state <= ST_SETTLE;
          r_enb   <= 1'b0;
          r_modo  <= MODO_HOLD;
          r_d     <= '0;
        end
        ST_SHIFT: begin
          // S_OUT of this cycle is the bit the register drops now.
          r_rdata[r_idx[IW-1:0]] <= S_OUT;
          if (w_last) begin
            r_state <= ST_SETTLE;
            r_enb   <= 1'b0;
            r_modo  <= MODO_HOLD;
            r_dir   <= 1'b0;
            r_sin   <= 1'b0;
          end else begin
            r_idx <= w_nidx;
            r_sin <= r_sdata[w_nidx[IW-1:0]];
          end
        end
        ST_ROTATE: begin
          if (w_last) begin
            r_state <= ST_SETTLE;
            r_enb   <= 1'b0;
            r_modo  <= MODO_HOLD;
            r_dir   <= 1'b0;
          end else begin
            r_idx <= w_nidx;
          end
        end
        ST_SETTLE: begin
          // Q reflects the last active edge by now.
          r_rq    <= Q;
          r_valid <= 1'b1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.RSP_READY) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg4_sequencer.sv
// Bench for reg4_sequencer driving register4.
// Transaction-level model of register and response, checked every cycle.
module tb_reg4_sequencer;
  logic       clk;
  logic       rst;
  logic       enb;
  logic [1:0] modo;
  logic       dir;
  logic [3:0] d;
  logic       s_in;
  logic       s_out;
  logic [3:0] q;

  reg4_sequencer_if #(.MAX_SHIFT(8)) bus ();

  reg4_sequencer #(.MAX_SHIFT(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus),
    .ENB   (enb),
    .MODO  (modo),
    .DIR   (dir),
    .D     (d),
    .S_IN  (s_in),
    .S_OUT (s_out),
    .Q     (q)
  );

  register4 u_reg (
    .CLK   (clk),
    .ENB   (enb),
    .MODO  (modo),
    .DIR   (dir),
    .D     (d),
    .S_IN  (s_in),
    .S_OUT (s_out),
    .Q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // expected outputs after the most recent edge
  int e_enb, e_modo, e_dir, e_d, e_sin;
  int e_rdy, e_rv, e_rdata, e_rq;
  bit m_dir, m_d, m_sin;
  bit chk_en = 1'b0;

  int mq;        // register contents model
  int ed, lat, n_enb;
  int g_rdata, g_q;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("enb", int'(enb), e_enb);
      chk("modo", int'(modo), e_modo);
      if (m_dir) chk("dir", int'(dir), e_dir);
      if (m_d) chk("d", int'(d), e_d);
      if (m_sin) chk("s_in", int'(s_in), e_sin);
      chk("cmd_ready", int'(bus.CMD_READY), e_rdy);
      chk("rsp_valid", int'(bus.RSP_VALID), e_rv);
      if (e_rv != 0) begin
        chk("rsp_data", int'(bus.RSP_DATA), e_rdata);
        chk("rsp_q", int'(bus.RSP_Q), e_rq);
      end
    end
  end

  task automatic set_quiet(input int rdy);
    e_enb = 0; e_modo = 3; e_dir = 0;
    e_d = 0; e_sin = 0;
    m_dir = 1; m_d = 1; m_sin = 1;
    e_rdy = rdy; e_rv = 0;
  endtask

  // active cycle k of a command; also applies that cycle's
  // effect to the register model at the following edge
  task automatic model_cycle(input int op, input int dr,
                             input int dat, input int sd,
                             input int k);
    int so;
    e_enb = 1; e_rdy = 0; e_rv = 0;
    m_dir = 0; m_d = 0; m_sin = 0;
    case (op)
      2: begin
        e_modo = 2; e_d = dat; m_d = 1;
        mq = dat;
      end
      0: begin
        e_modo = 0; e_dir = dr; m_dir = 1;
        e_sin = (sd >> k) & 1; m_sin = 1;
        if (dr == 0) begin
          so = (mq >> 3) & 1;
          mq = ((mq << 1) | e_sin) & 15;
        end else begin
          so = mq & 1;
          mq = (mq >> 1) | (e_sin << 3);
        end
        e_rdata = e_rdata | (so << k);
      end
      default: begin
        e_modo = 1; e_dir = dr; m_dir = 1;
        if (dr == 0) mq = ((mq << 1) | (mq >> 3)) & 15;
        else mq = (mq >> 1) | ((mq & 1) << 3);
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ed++;
    if (enb) n_enb++;
    if (bus.RSP_VALID && lat < 0) lat = ed;
  endtask

  task automatic noise();
    bus.CMD_VALID = 1'($urandom_range(0, 1));
    bus.CMD_OP    = 2'($urandom);
    bus.CMD_DIR   = 1'($urandom);
    bus.CMD_COUNT = 4'($urandom);
    bus.CMD_DATA  = 4'($urandom);
    bus.CMD_SDATA = 8'($urandom);
    bus.RSP_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input int op, input int dr,
                       input int cnt, input int dat,
                       input int sd);
    ed = -1; lat = -1; n_enb = 0; e_rdata = 0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = 2'(op);
    bus.CMD_DIR   = 1'(dr);
    bus.CMD_COUNT = 4'(cnt);
    bus.CMD_DATA  = 4'(dat);
    bus.CMD_SDATA = 8'(sd);
    step();
  endtask

  task automatic run_cmd(input int op, input int dr,
                         input int cnt, input int dat,
                         input int sd, input int hold);
    int n;
    case (op)
      2: n = 1;
      3: n = 0;
      0: n = (cnt > 8) ? 8 : cnt;
      default: n = cnt;
    endcase
    issue(op, dr, cnt, dat, sd);
    for (int k = 0; k < n; k++) begin
      model_cycle(op, dr, dat, sd, k);
      noise();
      step();
    end
    set_quiet(0);
    noise();
    step();
    e_rv = 1;
    e_rq = mq;
    bus.CMD_VALID = 1'b0;
    bus.RSP_READY = 1'b0;
    g_rdata = int'(bus.RSP_DATA);
    g_q = int'(bus.RSP_Q);
    repeat (hold) step();
    bus.RSP_READY = 1'b1;
    step();
    bus.RSP_READY = 1'b0;
    set_quiet(1);
  endtask

  initial begin
    rst = 1'b1;
    mq = 0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = '0;
    bus.CMD_DIR   = 1'b0;
    bus.CMD_COUNT = '0;
    bus.CMD_DATA  = '0;
    bus.CMD_SDATA = '0;
    bus.RSP_READY = 1'b0;
    set_quiet(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(bus.CMD_READY), 1);
    chk("rst_valid", int'(bus.RSP_VALID), 0);
    chk("rst_rdata", int'(bus.RSP_DATA), 0);
    chk("rst_rq", int'(bus.RSP_Q), 0);
    chk("rst_modo", int'(modo), 3);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    run_cmd(2, 0, 0, 4'b1010, 0, 0);
    chk("load_q", g_q, 4'b1010);
    chk("load_data", g_rdata, 0);
    chk("load_lat", lat, 2);
    chk("load_enb", n_enb, 1);

    run_cmd(2, 0, 0, 4'b1100, 0, 0);
    run_cmd(0, 0, 4, 0, 8'h03, 0);
    chk("shl_data", g_rdata, 8'h03);
    chk("shl_q", g_q, 4'b1100);
    chk("shl_lat", lat, 5);

    run_cmd(2, 0, 0, 4'b1100, 0, 1);
    run_cmd(0, 1, 3, 0, 8'h01, 0);
    chk("shr_data", g_rdata, 8'h04);
    chk("shr_q", g_q, 4'b0011);

    run_cmd(2, 0, 0, 4'b1010, 0, 0);
    run_cmd(1, 0, 5, 0, 8'hff, 0);
    chk("rot_q", g_q, 4'b0101);
    chk("rot_data", g_rdata, 0);
    chk("rot_enb", n_enb, 5);

    run_cmd(0, 1, 12, 0, 8'hA5, 0);
    chk("clamp_enb", n_enb, 8);
    chk("clamp_lat", lat, 9);

    run_cmd(2, 0, 0, 4'b0111, 0, 0);
    run_cmd(0, 0, 0, 0, 8'hff, 3);
    chk("cnt0_enb", n_enb, 0);
    chk("cnt0_lat", lat, 1);
    chk("cnt0_q", g_q, 4'b0111);

    // reset in the 2nd cycle of a 6-cycle shift
    run_cmd(2, 0, 0, 4'b0110, 0, 0);
    issue(0, 0, 6, 0, 8'h02);
    model_cycle(0, 0, 0, 8'h02, 0);
    noise();
    step();
    model_cycle(0, 0, 0, 8'h02, 1);
    bus.CMD_VALID = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_quiet(1);
    chk("mid_rst_ready", int'(bus.CMD_READY), 1);
    chk("mid_rst_enb", int'(enb), 0);
    chk("mid_rst_modo", int'(modo), 3);
    chk("mid_rst_valid", int'(bus.RSP_VALID), 0);
    run_cmd(3, 0, 0, 0, 0, 0);
    chk("mid_rst_q", g_q, 4'b1001);
    run_cmd(2, 0, 0, 4'b1011, 0, 1);
    chk("after_rst_load", g_q, 4'b1011);
    chk("after_rst_lat", lat, 2);

    for (int i = 0; i < 60; i++) begin
      run_cmd($urandom_range(0, 3),
              $urandom_range(0, 1),
              $urandom_range(0, 15),
              $urandom_range(0, 15),
              $urandom_range(0, 255),
              $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
